compare_result_tracker: RTL
===========================

Name: compare_result_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator's eq/gt/sm outputs.
- Samples the one-hot relation on qualified cycles and debounces it: a relation is committed only after STABLE_CNT consecutive identical legal samples.
- Reports the committed relation, pulses on each relation change and keeps saturating per-relation entry counters.
- Flags illegal (non-one-hot) comparator outputs with a sticky error.

Parameters:
- STABLE_CNT, 3, consecutive identical legal samples required to commit a relation (legal range 1..15).
- CNT_W, 8, width of each per-relation entry counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  eq/gt/sm are sampled this cycle.
- eq  input  1  comparator: a == b.
- gt  input  1  comparator: a > b.
- sm  input  1  comparator: a < b.
- clr  input  1  synchronous clear of state, counters and error (active high).
- rel_state  output  2  committed relation: IDLE=00, EQ=01, GT=10, SM=11.
- rel_valid  output  1  high while rel_state != IDLE.
- change_pulse  output  1  single-cycle pulse on each commit.
- eq_count  output  CNT_W  number of commits into EQ, saturating.
- gt_count  output  CNT_W  number of commits into GT, saturating.
- sm_count  output  CNT_W  number of commits into SM, saturating.
- err  output  1  sticky: a non-one-hot sample was seen while in_valid=1.

Behaviour:
- Reset (rst_n=0 at an edge): rel_state=IDLE, rel_valid=0, change_pulse=0, all counts=0, err=0, internal cand=IDLE, run=0.
- clr=1 at an edge: identical effect to reset. Priority is rst_n > clr > sample.
- Sample classification with in_valid=1: a legal sample has exactly one of {eq,gt,sm} high, and code = EQ/GT/SM accordingly. Any other pattern is illegal.
- in_valid=0: no state change. cand and run are held, so gaps do not break a run.
- Illegal sample: err<=1 (sticky until reset/clr), run<=0, cand<=IDLE. rel_state is unchanged.
- Legal sample with code != cand: cand<=code, run<=1.
- Legal sample with code == cand: run<=min(run+1, STABLE_CNT).
- Commit condition, evaluated on the incoming sample: legal, new run value == STABLE_CNT, and code != rel_state.
- On the commit edge: rel_state<=code, rel_valid<=1, change_pulse<=1, and the matching counter increments.
- Commit latency: outputs are updated on the same edge that samples the STABLE_CNT-th identical sample.
- change_pulse is high for exactly one cycle after the commit edge. It deasserts on the next edge unless another commit occurs on that edge, which is only possible when STABLE_CNT=1.
- Same relation as the committed one reaching STABLE_CNT: no pulse, no count. run saturates at STABLE_CNT.
- STABLE_CNT=1: every legal sample that differs from rel_state commits immediately.
- Counters saturate at 2^CNT_W-1 and never wrap. Saturation does not suppress change_pulse.
- rel_state is never returned to IDLE except by reset or clr. Illegal samples do not clear the committed relation.
- Run counter width: 4 bits, sufficient for STABLE_CNT<=15.

Decomposition:
- Shared package cmp_pkg holds the relation encodings (REL_IDLE, REL_EQ, REL_GT, REL_SM) and a function mapping {eq,gt,sm} to code plus a legal flag, for reuse by the comparator bench.
- One natural sub-module: sat_counter (parameter W; ports clk, rst_n, clr, inc, count), instantiated three times.
- Debounce/commit logic stays in the top module.

Test Plan (STABLE_CNT=3, CNT_W=8 unless stated):
1. Hold rst_n=0 for 2 cycles with random eq/gt/sm -> rel_state=00, rel_valid=0, change_pulse=0, all counts=0, err=0.
2. Three valid gt samples (a=0011, b=0001) with an in_valid=0 gap cycle between the 2nd and 3rd -> on the 3rd sample edge rel_state=10, rel_valid=1, gt_count=1; change_pulse is high for exactly 1 cycle.
3. Sample sequence gt,gt,eq,gt,gt,gt -> no commit until the 6th sample, then rel_state=10, gt_count=1, eq_count=0. A further 3 gt samples give no pulse and gt_count stays 1.
4. Sample sequence gt,gt,{eq=1,gt=1,sm=0},gt -> err=1 and remains 1, no commit (rel_state=00). Two more gt samples then commit GT.
5. CNT_W=2, STABLE_CNT=1, alternate sm/gt for 10 samples -> 10 change pulses; sm_count=3 and gt_count=3 (saturated); rel_state=10 after the last sample.
6. Commit EQ (a=b=1001), then drive clr=1 in the same cycle as the 3rd sm sample -> next cycle rel_state=00, all counts=0, err=0, change_pulse=0, and no SM commit occurs.

Source files
------------

// File: rtl/cmp_pkg.sv
// =============================================================================
// Module  : cmp_pkg
// Brief   : Relation encodings and sample classification for the comparator.
// Revision: 1.0
// =============================================================================
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    REL_IDLE = 2'b00,
    REL_EQ   = 2'b01,
    REL_GT   = 2'b10,
    REL_SM   = 2'b11
  } rel_e;

  typedef struct packed {
    logic legal;
    rel_e code;
  } classify_t;

  localparam int c_RUN_W = 4;

  // Only a strictly one-hot {eq,gt,sm} is a legal comparator result.
  function automatic classify_t classify(input logic eq, input logic gt, input logic sm);
    classify_t r;
    r.legal = 1'b1;
    r.code  = REL_IDLE;
    case ({eq, gt, sm})
      3'b100:  r.code = REL_EQ;
      3'b010:  r.code = REL_GT;
      3'b001:  r.code = REL_SM;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// =============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones; synchronous reset and clear.
// Revision: 1.0
// =============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/compare_result_tracker.sv
// =============================================================================
// Module  : compare_result_tracker
// Brief   : Debounces comparator eq/gt/sm, commits relations, counts entries.
// Revision: 1.0
// =============================================================================
`default_nettype none

module compare_result_tracker
  import cmp_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             gt,
  input  logic             sm,
  input  logic             clr,
  output logic [1:0]       rel_state,
  output logic             rel_valid,
  output logic             change_pulse,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] sm_count,
  output logic             err
);

  localparam logic [c_RUN_W-1:0] c_STABLE = c_RUN_W'(STABLE_CNT);

  classify_t          w_cls;
  logic               w_commit;
  rel_e               rel_q,   rel_d;
  rel_e               cand_q,  cand_d;
  logic [c_RUN_W-1:0] run_q,   run_d;
  logic               pulse_q, pulse_d;
  logic               err_q,   err_d;

  always_comb begin
    w_cls    = classify(eq, gt, sm);
    w_commit = 1'b0;
    rel_d    = rel_q;
    cand_d   = cand_q;
    run_d    = run_q;
    pulse_d  = 1'b0;
    err_d    = err_q;
    if (in_valid) begin
      if (!w_cls.legal) begin
        err_d  = 1'b1;
        run_d  = '0;
        cand_d = REL_IDLE;
      end else begin
        if (w_cls.code != cand_q) begin
          cand_d = w_cls.code;
          run_d  = c_RUN_W'(1);
        end else if (run_q < c_STABLE) begin
          run_d = run_q + c_RUN_W'(1);
        end else begin
          run_d = c_STABLE;
        end
        // Commit is judged on the updated run so latency is zero extra cycles.
        if ((run_d == c_STABLE) && (w_cls.code != rel_q)) begin
          w_commit = 1'b1;
          rel_d    = w_cls.code;
          pulse_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rel_q   <= REL_IDLE;
      cand_q  <= REL_IDLE;
      run_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rel_q   <= rel_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_commit && (w_cls.code == REL_EQ)),
    .count (eq_count)
  );

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_commit && (w_cls.code == REL_GT)),
    .count (gt_count)
  );

  sat_counter #(.W(CNT_W)) u_sm_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_commit && (w_cls.code == REL_SM)),
    .count (sm_count)
  );

  assign rel_state    = rel_q;
  assign rel_valid    = (rel_q != REL_IDLE);
  assign change_pulse = pulse_q;
  assign err          = err_q;

endmodule

`default_nettype wire
